// File: rtl/prbs_pkg.sv
// PRBS31 shared constants and checker state encoding.
// The generator uses the same taps.
package prbs_pkg;

  localparam int PRBS31_TAP_A = 30;
  localparam int PRBS31_TAP_B = 27;
  localparam int PRBS31_LEN   = 31;

  typedef enum logic [1:0] {
    SEED,
    VERIFY,
    LOCKED
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear with a simultaneous increment loads 1.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= W'(inc);
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 (x^31+x^28+1) serial checker
// with lock detection and saturating error/bit counters.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LOCK_BITS  = 64,
  parameter int LOS_WINDOW = 128,
  parameter int LOS_ERRS   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FILL_W = $clog2(PRBS31_LEN);
  localparam int LOCK_W = $clog2(LOCK_BITS);
  localparam int WIN_W  = $clog2(LOS_WINDOW);
  localparam int TAL_W  = $clog2(LOS_ERRS + 1);

  state_t                  state;
  logic [PRBS31_LEN-1:0]   r;
  logic [FILL_W-1:0]       fill;
  logic [LOCK_W-1:0]       run;
  logic [WIN_W-1:0]        win;
  logic [TAL_W-1:0]        tally;

  logic                    pred;
  logic                    mis;
  logic [PRBS31_LEN-1:0]   r_rx;
  logic [TAL_W-1:0]        tally_nxt;
  logic                    err_inc;
  logic                    bit_inc;

  assign pred      = r[PRBS31_TAP_A] ^ r[PRBS31_TAP_B];
  assign mis       = bit_in ^ pred;
  assign r_rx      = {r[PRBS31_LEN-2:0], bit_in};
  assign tally_nxt = tally + TAL_W'(mis);
  assign bit_inc   = bit_valid && (state == LOCKED);
  assign err_inc   = bit_inc && mis;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= SEED;
      r         <= '0;
      fill      <= '0;
      run       <= '0;
      win       <= '0;
      tally     <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          SEED: begin
            r <= r_rx;
            if (fill == FILL_W'(PRBS31_LEN - 1)) begin
              fill <= '0;
              // an all-zero seed would predict zeros forever
              if (r_rx != '0) begin
                state <= VERIFY;
                run   <= '0;
              end
            end else begin
              fill <= fill + 1'b1;
            end
          end
          VERIFY: begin
            r <= r_rx;
            if (mis) begin
              state <= SEED;
              fill  <= '0;
            end else if (run == LOCK_W'(LOCK_BITS - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
              win    <= '0;
              tally  <= '0;
            end else begin
              run <= run + 1'b1;
            end
          end
          LOCKED: begin
            // flywheel: received errors never enter the reference
            r         <= {r[PRBS31_LEN-2:0], pred};
            err_pulse <= mis;
            if (tally_nxt >= TAL_W'(LOS_ERRS)) begin
              state  <= SEED;
              locked <= 1'b0;
              fill   <= '0;
            end else if (win == WIN_W'(LOS_WINDOW - 1)) begin
              win   <= '0;
              tally <= '0;
            end else begin
              win   <= win + 1'b1;
              tally <= tally_nxt;
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst_n),
    .clr (err_clr),
    .inc (err_inc),
    .q   (err_count)
  );

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk (clk),
    .rst (rst_n),
    .clr (err_clr),
    .inc (bit_inc),
    .q   (bit_count)
  );

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: generator stream,
// reference model feeding a scoreboard, plus spot checks.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] bit_count;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  typedef struct {
    logic        lk;
    logic        pl;
    logic [15:0] ec;
    logic [15:0] bc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // transmit generator, same polynomial, seeded with 1
  logic [30:0] g = 31'd1;

  // reference model state; hq[0] is the oldest of the last 31 bits
  bit hq[$];
  int m_mode, m_fill, m_run, m_win, m_tally, m_err, m_bits;
  bit m_pulse;

  function automatic logic gen_next();
    logic b;
    b = g[30];
    g = {g[29:0], g[30] ^ g[27]};
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hpush(input bit x);
    void'(hq.pop_front());
    hq.push_back(x);
  endtask

  task automatic model(input logic b, input logic v,
                       input logic c, input logic rs);
    bit pr, mis, nz;
    if (rs) begin
      m_mode = 0; m_fill = 0; m_run = 0; m_win = 0;
      m_tally = 0; m_err = 0; m_bits = 0; m_pulse = 0;
      hq = {};
      repeat (31) hq.push_back(1'b0);
    end else begin
      m_pulse = 0;
      if (c) begin
        m_err = 0;
        m_bits = 0;
      end
      if (v) begin
        pr  = hq[0] ^ hq[3];
        mis = b ^ pr;
        case (m_mode)
          0: begin
            hpush(b);
            m_fill++;
            if (m_fill == 31) begin
              m_fill = 0;
              nz = 0;
              foreach (hq[i]) nz |= hq[i];
              if (nz) begin
                m_mode = 1;
                m_run = 0;
              end
            end
          end
          1: begin
            hpush(b);
            if (mis) begin
              m_mode = 0;
              m_fill = 0;
            end else begin
              m_run++;
              if (m_run == 64) begin
                m_mode = 2;
                m_win = 0;
                m_tally = 0;
              end
            end
          end
          default: begin
            hpush(pr);
            m_pulse = mis;
            if (m_bits < 65535) m_bits++;
            if (mis && m_err < 65535) m_err++;
            m_tally += int'(mis);
            if (m_tally >= 8) begin
              m_mode = 0;
              m_fill = 0;
            end else begin
              m_win++;
              if (m_win == 128) begin
                m_win = 0;
                m_tally = 0;
              end
            end
          end
        endcase
      end
    end
  endtask

  task automatic step(input logic b, input logic v,
                      input logic c, input logic rs);
    exp_t e;
    @(negedge clk);
    bit_in = b;
    bit_valid = v;
    err_clr = c;
    rst_n = rs;
    model(b, v, c, rs);
    e.lk = (m_mode == 2);
    e.pl = m_pulse;
    e.ec = m_err[15:0];
    e.bc = m_bits[15:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (locked !== e.lk) chk("sb_locked", {31'd0, locked}, {31'd0, e.lk});
    else checks++;
    if (err_pulse !== e.pl) chk("sb_pulse", {31'd0, err_pulse}, {31'd0, e.pl});
    else checks++;
    if (err_count !== e.ec) chk("sb_errcnt", {16'd0, err_count}, {16'd0, e.ec});
    else checks++;
    if (bit_count !== e.bc) chk("sb_bitcnt", {16'd0, bit_count}, {16'd0, e.bc});
    else checks++;
  endtask

  task automatic good();
    step(gen_next(), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic bad();
    step(~gen_next(), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int n, first, pulses, lk_seen;
    hq = {};
    repeat (31) hq.push_back(1'b0);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_errcnt", {16'd0, err_count}, 32'd0);
    chk("rst_bitcnt", {16'd0, bit_count}, 32'd0);

    // acquisition from a clean stream
    first = 0;
    n = 0;
    while (first == 0 && n < 300) begin
      good();
      n++;
      if (locked) first = n;
    end
    chk("lock_point", first, 95);
    chk("lock_errcnt", {16'd0, err_count}, 32'd0);

    // single error while locked
    n = 0;
    while (m_bits != 1000 && n < 2000) begin
      good();
      n++;
    end
    bad();
    chk("single_pulse", {31'd0, err_pulse}, 32'd1);
    chk("single_errcnt", {16'd0, err_count}, 32'd1);
    chk("single_locked", {31'd0, locked}, 32'd1);
    pulses = 0;
    repeat (200) begin
      good();
      pulses += int'(err_pulse);
    end
    chk("flywheel_pulses", pulses, 0);
    chk("flywheel_locked", {31'd0, locked}, 32'd1);

    // burst of 8 errors inside one window
    n = 0;
    while (m_win != 0 && n < 200) begin
      good();
      n++;
    end
    for (int k = 0; k < 8; k++) begin
      bad();
      if (k < 7) begin
        chk("burst_hold", {31'd0, locked}, 32'd1);
        repeat (3) good();
      end
    end
    chk("los_locked", {31'd0, locked}, 32'd0);
    first = 0;
    n = 0;
    while (first == 0 && n < 300) begin
      good();
      n++;
      if (locked) first = n;
    end
    chk("relock_point", first, 95);

    // all-zero input never seeds
    step(1'b0, 1'b0, 1'b0, 1'b1);
    lk_seen = 0;
    repeat (200) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      lk_seen |= int'(locked);
    end
    chk("zeros_nolock", lk_seen, 0);
    n = 0;
    while (!locked && n < 400) begin
      good();
      n++;
    end
    chk("zeros_then_lock", {31'd0, locked}, 32'd1);

    // err_clr concurrent with an error loads 1
    bad();
    bad();
    chk("pre_clr_errcnt", {16'd0, err_count}, 32'd2);
    step(~gen_next(), 1'b1, 1'b1, 1'b0);
    chk("clr_inc_errcnt", {16'd0, err_count}, 32'd1);
    chk("clr_inc_bitcnt", {16'd0, bit_count}, 32'd1);

    // bit_count saturation
    n = 0;
    while (m_bits < 65535 && n < 70000) begin
      good();
      n++;
    end
    repeat (5) good();
    chk("sat_bitcnt", {16'd0, bit_count}, 32'h0000ffff);
    bad();
    chk("sat_bitcnt_err", {16'd0, bit_count}, 32'h0000ffff);
    chk("sat_errcnt_inc", {16'd0, err_count}, 32'd2);

    // reset mid-lock, then 50% valid duty
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk("mid_rst_errcnt", {16'd0, err_count}, 32'd0);
    chk("mid_rst_bitcnt", {16'd0, bit_count}, 32'd0);
    first = 0;
    n = 0;
    while (first == 0 && n < 300) begin
      step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
      good();
      n++;
      if (locked) first = n;
    end
    chk("gap_lock_point", first, 95);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
